// File: rtl/ddr_arb_pkg.sv
// Shared types and defaults for the two-channel DDR write arbiter.
//   arb_state_t : arbiter FSM states
//   arb_word_t  : FIFO entry, {sof tag, 64-bit packed pixel word}
package ddr_arb_pkg;

  localparam int unsigned DATA_W          = 64;
  localparam int unsigned WORD_W          = DATA_W + 1;
  localparam int unsigned DEF_BURST_LEN   = 16;
  localparam int unsigned DEF_FRAME_WORDS = 115200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    BURST = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              sof;
    logic [DATA_W-1:0] data;
  } arb_word_t;

endpackage

// File: rtl/ddr_arb_fifo.sv
// Single-clock show-ahead FIFO, one per camera channel.
//   clk_sys, reset : clock, async active-high reset
//   i_wr, i_wdata  : write strobe and entry (ignored while full)
//   i_rd           : pop the head entry
//   o_head         : current head entry (valid while level > 0)
//   o_next         : entry behind the head (valid while level > 1)
//   o_full         : no free slot
//   o_level        : number of stored entries
module ddr_arb_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 65
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_head,
  output logic [WIDTH-1:0]         o_next,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_level = r_level;
  assign w_wr    = i_wr & ~o_full;
  assign w_rd    = i_rd & (r_level != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_next  = r_mem[r_rd_ptr + PTR_W'(1)];

  // Storage array, no reset needed
  always_ff @(posedge clk_sys) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers and fill level
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ddr_wr_arbiter_2ch.sv
// Two-channel DDR write scheduler: buffers the packed words of two camera
// streams and issues fixed-length Avalon-MM write bursts round-robin, with
// per-channel double-buffered frame addressing.
// Optional feature macro: DDR_ARB_STATS_EN adds burst_cnt_1/burst_cnt_2/stall_cnt.
//   clk_sys, reset        : clock, async active-high reset
//   chN_data/valid/sof    : channel N word, strobe, first-word-of-frame tag
//   avm_*                 : Avalon-MM burst write master
//   frame_done            : per-channel pulse when a frame's last word is accepted
//   rd_buf                : per-channel index of the last completed buffer
//   ovf, sof_err          : sticky per-channel errors, cleared by clr_status
module ddr_wr_arbiter_2ch
  import ddr_arb_pkg::*;
#(
  parameter int unsigned       BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned       FIFO_DEPTH  = 64,
  parameter int unsigned       FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int unsigned       ADDR_W      = 27,
  parameter logic [ADDR_W-1:0] CH1_BASE    = 'h0000000,
  parameter logic [ADDR_W-1:0] CH2_BASE    = 'h0040000,
  parameter logic [ADDR_W-1:0] BUF_STRIDE  = 'h0020000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [63:0]       ch1_data,
  input  logic              ch1_valid,
  input  logic              ch1_sof,
  input  logic [63:0]       ch2_data,
  input  logic              ch2_valid,
  input  logic              ch2_sof,
  output logic [ADDR_W-1:0] avm_address,
  output logic [6:0]        avm_burstcount,
  output logic              avm_write,
  output logic [63:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic [1:0]        frame_done,
  output logic [1:0]        rd_buf,
  output logic [1:0]        ovf,
  output logic [1:0]        sof_err,
`ifdef DDR_ARB_STATS_EN
  output logic [31:0]       burst_cnt_1,
  output logic [31:0]       burst_cnt_2,
  output logic [31:0]       stall_cnt,
`endif
  input  logic              clr_status
);

  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic [1:0]              w_valid;
  arb_word_t [1:0]         w_din;
  arb_word_t [1:0]         w_head;
  arb_word_t [1:0]         w_next;
  logic [1:0]              w_full;
  logic [1:0][LVL_W-1:0]   w_level;
  logic [1:0]              w_rdy;
  logic [1:0]              w_pop;

  logic                    r_write;
  logic [ADDR_W-1:0]       r_addr;
  logic [63:0]             r_wdata;
  logic                    r_gnt;
  logic                    r_rr;
  logic [BEAT_W-1:0]       r_beat;

  logic [1:0][ADDR_W-1:0]  r_offset;
  logic [1:0]              r_wr_buf;
  logic [1:0]              r_no_tog;
  logic [1:0]              r_rd_buf;
  logic [1:0]              r_frame_done;
  logic [1:0]              r_ovf;
  logic [1:0]              r_sof_err;

  logic                    w_arb;
  logic                    w_done;
  logic                    w_gnt_sel;
  logic                    w_beat_ok;
  logic                    w_load_nxt;
  arb_word_t               w_sel_head;
  arb_word_t               w_cur_next;
  logic                    w_tog;
  logic                    w_buf_n;
  logic [ADDR_W-1:0]       w_off_n;
  logic [ADDR_W-1:0]       w_arb_addr;
  logic [ADDR_W-1:0]       w_off_sum;
  logic                    w_frame_end;
  logic [1:0]              w_sof_set;

  // Per-channel input FIFOs
  assign w_valid  = {ch2_valid, ch1_valid};
  assign w_din[0] = {ch1_sof, ch1_data};
  assign w_din[1] = {ch2_sof, ch2_data};

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    ddr_arb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
    ) u_fifo (
      .clk_sys (clk_sys),
      .reset   (reset),
      .i_wr    (w_valid[gi]),
      .i_wdata (w_din[gi]),
      .i_rd    (w_pop[gi]),
      .o_head  (w_head[gi]),
      .o_next  (w_next[gi]),
      .o_full  (w_full[gi]),
      .o_level (w_level[gi])
    );
    assign w_rdy[gi] = (w_level[gi] >= LVL_W'(BURST_LEN));
  end

  // Beat handshake; each accepted beat retires the FIFO head of the granted channel
  assign w_beat_ok  = r_write & ~avm_waitrequest;
  assign w_load_nxt = w_beat_ok & (r_beat != BEAT_LAST);
  assign w_pop      = {w_beat_ok & r_gnt, w_beat_ok & ~r_gnt};

  // Start-of-burst address; an SOF tag opens the other buffer unless a frame just closed
  assign w_sel_head = w_head[w_gnt_sel];
  assign w_tog      = w_sel_head.sof & ~r_no_tog[w_gnt_sel];
  assign w_buf_n    = r_wr_buf[w_gnt_sel] ^ w_tog;
  assign w_off_n    = w_tog ? '0 : r_offset[w_gnt_sel];
  assign w_arb_addr = (w_gnt_sel ? CH2_BASE : CH1_BASE)
                    + (w_buf_n ? BUF_STRIDE : '0)
                    + w_off_n;

  // End-of-burst bookkeeping for the granted channel
  assign w_cur_next  = w_next[r_gnt];
  assign w_off_sum   = r_offset[r_gnt] + ADDR_W'(BURST_LEN);
  assign w_frame_end = (w_off_sum == ADDR_W'(FRAME_WORDS));
  assign w_sof_set   = {w_load_nxt & w_cur_next.sof & r_gnt,
                        w_load_nxt & w_cur_next.sof & ~r_gnt};

  // FSM state register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_arb       = 1'b0;
    w_done      = 1'b0;
    w_gnt_sel   = r_rr;
    unique case (r_state)
      IDLE: begin
        if (|w_rdy) w_state_nxt = ARB;
      end
      ARB: begin
        w_arb       = 1'b1;
        // with one channel ready its index is w_rdy[1]
        w_gnt_sel   = (&w_rdy) ? r_rr : w_rdy[1];
        w_state_nxt = BURST;
      end
      BURST: begin
        if (w_beat_ok && (r_beat == BEAT_LAST)) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Avalon master registers; write data always holds the word of the current beat
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_gnt   <= 1'b0;
      r_rr    <= 1'b0;
      r_beat  <= '0;
    end else if (w_arb) begin
      r_write <= 1'b1;
      r_addr  <= w_arb_addr;
      r_wdata <= w_sel_head.data;
      r_gnt   <= w_gnt_sel;
      r_beat  <= '0;
    end else if (w_done) begin
      r_write <= 1'b0;
      r_rr    <= ~r_gnt;
    end else if (w_load_nxt) begin
      r_beat  <= r_beat + BEAT_W'(1);
      r_wdata <= w_cur_next.data;
    end
  end

  // Per-channel frame offset and buffer selection
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_offset     <= '0;
      r_wr_buf     <= '0;
      r_no_tog     <= '0;
      r_rd_buf     <= '0;
      r_frame_done <= '0;
    end else begin
      r_frame_done <= '0;
      if (w_arb) begin
        r_wr_buf[w_gnt_sel] <= w_buf_n;
        r_offset[w_gnt_sel] <= w_off_n;
        r_no_tog[w_gnt_sel] <= 1'b0;
      end
      if (w_done) begin
        if (w_frame_end) begin
          r_frame_done[r_gnt] <= 1'b1;
          r_rd_buf[r_gnt]     <= r_wr_buf[r_gnt];
          r_wr_buf[r_gnt]     <= ~r_wr_buf[r_gnt];
          r_offset[r_gnt]     <= '0;
          r_no_tog[r_gnt]     <= 1'b1;
        end else begin
          r_offset[r_gnt]     <= w_off_sum;
        end
      end
    end
  end

  // Sticky error flags; a new event in the clear cycle keeps its flag set
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_ovf     <= '0;
      r_sof_err <= '0;
    end else begin
      r_ovf     <= (r_ovf     & ~{2{clr_status}}) | (w_valid & w_full);
      r_sof_err <= (r_sof_err & ~{2{clr_status}}) | w_sof_set;
    end
  end

`ifdef DDR_ARB_STATS_EN
  logic [31:0] r_bcnt1;
  logic [31:0] r_bcnt2;
  logic [31:0] r_stall;

  // Completed bursts per channel and stalled write cycles
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_bcnt1 <= '0;
      r_bcnt2 <= '0;
      r_stall <= '0;
    end else begin
      r_bcnt1 <= (clr_status ? 32'd0 : r_bcnt1) + 32'(w_done & ~r_gnt);
      r_bcnt2 <= (clr_status ? 32'd0 : r_bcnt2) + 32'(w_done & r_gnt);
      r_stall <= r_stall + 32'(r_write & avm_waitrequest);
    end
  end

  assign burst_cnt_1 = r_bcnt1;
  assign burst_cnt_2 = r_bcnt2;
  assign stall_cnt   = r_stall;
`endif

  assign avm_address    = r_addr;
  assign avm_burstcount = 7'(BURST_LEN);
  assign avm_write      = r_write;
  assign avm_writedata  = r_wdata;
  assign frame_done     = r_frame_done;
  assign rd_buf         = r_rd_buf;
  assign ovf            = r_ovf;
  assign sof_err        = r_sof_err;

endmodule

// File: tb/tb_ddr_wr_arbiter_2ch.sv
// Scoreboard bench for ddr_wr_arbiter_2ch (short frame to keep runtime small).
module tb_ddr_wr_arbiter_2ch;

  localparam int unsigned BL = 16;
  localparam int unsigned FW = 64;
  localparam int unsigned AW = 27;
  localparam logic [AW-1:0] B1 = 27'h0000000;
  localparam logic [AW-1:0] B2 = 27'h0040000;
  localparam logic [AW-1:0] ST = 27'h0020000;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
  } exp_t;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   ch1_data = '0, ch2_data = '0;
  logic          ch1_valid = 1'b0, ch1_sof = 1'b0, ch2_valid = 1'b0, ch2_sof = 1'b0;
  logic [AW-1:0] avm_address;
  logic [6:0]    avm_burstcount;
  logic          avm_write;
  logic [63:0]   avm_writedata;
  logic          avm_waitrequest = 1'b0;
  logic [1:0]    frame_done, rd_buf, ovf, sof_err;
  logic          clr_status = 1'b0;
`ifdef DDR_ARB_STATS_EN
  logic [31:0]   burst_cnt_1, burst_cnt_2, stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_beats = 0;
  int fd0 = 0;
  int seq1 = 0;
  int seq2 = 0;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [64:0] mq0[$];
  logic [64:0] mq1[$];
  logic [1:0]  m_buf, m_notog, m_sof_err, m_rdbuf;
  int          m_off[2];

  always #5 clk_sys = ~clk_sys;

  ddr_wr_arbiter_2ch #(
    .BURST_LEN   (BL),
    .FIFO_DEPTH  (64),
    .FRAME_WORDS (FW),
    .ADDR_W      (AW)
  ) dut (
    .clk_sys         (clk_sys),
    .reset           (reset),
    .ch1_data        (ch1_data),
    .ch1_valid       (ch1_valid),
    .ch1_sof         (ch1_sof),
    .ch2_data        (ch2_data),
    .ch2_valid       (ch2_valid),
    .ch2_sof         (ch2_sof),
    .avm_address     (avm_address),
    .avm_burstcount  (avm_burstcount),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .frame_done      (frame_done),
    .rd_buf          (rd_buf),
    .ovf             (ovf),
    .sof_err         (sof_err),
`ifdef DDR_ARB_STATS_EN
    .burst_cnt_1     (burst_cnt_1),
    .burst_cnt_2     (burst_cnt_2),
    .stall_cnt       (stall_cnt),
`endif
    .clr_status      (clr_status)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of channel strobes; accepted words go to the model queues
  task automatic push(input logic v1, input logic f1, input logic v2, input logic f2);
    ch1_valid = v1; ch1_sof = f1; ch1_data = {32'h00C1_0000, 32'(seq1)};
    ch2_valid = v2; ch2_sof = f2; ch2_data = {32'h00C2_0000, 32'(seq2)};
    @(posedge clk_sys); #1;
    if (v1) begin mq0.push_back({f1, ch1_data}); seq1++; end
    if (v2) begin mq1.push_back({f2, ch2_data}); seq2++; end
    ch1_valid = 1'b0; ch1_sof = 1'b0; ch2_valid = 1'b0; ch2_sof = 1'b0;
  endtask

  // Predict the next burst of channel ch and queue its expected beats
  task automatic plan_burst(input int ch);
    logic [64:0]   w [BL];
    logic [AW-1:0] a;
    for (int i = 0; i < BL; i++) begin
      if (ch == 0) w[i] = mq0.pop_front();
      else         w[i] = mq1.pop_front();
    end
    if (w[0][64] && !m_notog[ch]) begin
      m_buf[ch] = ~m_buf[ch];
      m_off[ch] = 0;
    end
    m_notog[ch] = 1'b0;
    a = ((ch == 0) ? B1 : B2) + (m_buf[ch] ? ST : '0) + AW'(m_off[ch]);
    for (int i = 0; i < BL; i++) begin
      if (i > 0 && w[i][64]) m_sof_err[ch] = 1'b1;
      sb.push_back({a, w[i][63:0]});
    end
    m_off[ch] += BL;
    if (m_off[ch] == FW) begin
      m_rdbuf[ch] = m_buf[ch];
      m_buf[ch]   = ~m_buf[ch];
      m_off[ch]   = 0;
      m_notog[ch] = 1'b1;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk_sys);
      n++;
    end
    #1;
    check(tag, 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    avm_waitrequest = 1'b0;
    clr_status = 1'b0;
    sb.delete(); mq0.delete(); mq1.delete();
    m_buf = '0; m_notog = '0; m_sof_err = '0; m_rdbuf = '0;
    m_off[0] = 0; m_off[1] = 0;
    fd0 = 0;
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  // Beat monitor: every write cycle, including stalls, must show the expected beat
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (frame_done[0]) fd0++;
      if (avm_write) begin
        check("beat_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb[0];
          check("addr", 64'(avm_address), 64'(mon_e.addr));
          check("data", avm_writedata, mon_e.data);
          check("burstcount", 64'(avm_burstcount), 64'(BL));
          if (!avm_waitrequest) begin
            void'(sb.pop_front());
            n_beats++;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int nb0;
    // Reset values
    @(posedge clk_sys); #1;
    check("rst_write", 64'(avm_write), 64'd0);
    check("rst_addr", 64'(avm_address), 64'd0);
    check("rst_wdata", avm_writedata, 64'd0);
    check("rst_fdone", 64'(frame_done), 64'd0);
    check("rst_rdbuf", 64'(rd_buf), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_soferr", 64'(sof_err), 64'd0);
    do_reset();

    // Ch1 single burst with SOF, plus 2-cycle start latency
    for (int i = 0; i < BL; i++) push(1'b1, i == 0, 1'b0, 1'b0);
    plan_burst(0);
    @(negedge clk_sys); @(negedge clk_sys);
    check("latency_c1", 64'(avm_write), 64'd0);
    @(negedge clk_sys);
    check("latency_c2", 64'(avm_write), 64'd1);
    wait_drain("drain_single");

    // Both channels loaded: ch1, ch2, ch1, ch2
    do_reset();
    for (int i = 0; i < 2 * BL; i++) begin
      push(1'b1, i == 0, 1'b1, i == 0);
      if ((i % BL) == BL - 1) begin
        plan_burst(0);
        plan_burst(1);
      end
    end
    wait_drain("drain_rr");

    // Waitrequest on beats 3..7
    do_reset();
    for (int i = 0; i < BL; i++) push(1'b1, i == 0, 1'b0, 1'b0);
    plan_burst(0);
    nb0 = n_beats;
    n = 0;
    do begin
      @(posedge clk_sys); #1;
      n++;
    end while (!avm_write && n < 20);
    check("stall_start", 64'(avm_write), 64'd1);
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    avm_waitrequest = 1'b1;
    repeat (5) @(posedge clk_sys);
    #1 avm_waitrequest = 1'b0;
    wait_drain("drain_stall");
    check("stall_beats", 64'(n_beats - nb0), 64'(BL));

    // Full frame on ch1, then a new frame whose SOF must not toggle again
    do_reset();
    for (int i = 0; i < FW; i++) begin
      push(1'b1, i == 0, 1'b0, 1'b0);
      if ((i % BL) == BL - 1) plan_burst(0);
    end
    wait_drain("drain_frame");
    check("frame_done_cnt", 64'(fd0), 64'd1);
    check("rd_buf_frame", 64'(rd_buf), 64'(m_rdbuf));
    // second SOF on word 5 of the burst
    for (int i = 0; i < BL; i++) push(1'b1, (i == 0) || (i == 5), 1'b0, 1'b0);
    plan_burst(0);
    wait_drain("drain_newframe");
    check("sof_err_set", 64'(sof_err), 64'(m_sof_err));
    check("frame_done_once", 64'(fd0), 64'd1);
    clr_status = 1'b1;
    @(posedge clk_sys); #1 clr_status = 1'b0;
    check("sof_err_clr", 64'(sof_err), 64'd0);

    // Overflow on ch2 with the slave stalled
    do_reset();
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 65; i++) begin
      push(1'b0, 1'b0, 1'b1, i == 0);
      if (i == BL - 1) plan_burst(1);
    end
    check("ovf_set", 64'(ovf), 64'h2);
    ch2_valid = 1'b1; clr_status = 1'b1;
    @(posedge clk_sys); #1;
    ch2_valid = 1'b0; clr_status = 1'b0;
    check("ovf_set_wins", 64'(ovf), 64'h2);
    clr_status = 1'b1;
    @(posedge clk_sys); #1 clr_status = 1'b0;
    check("ovf_clr", 64'(ovf), 64'd0);

    // Reset mid-burst drops avm_write without a clock edge
    check("stuck_write", 64'(avm_write), 64'd1);
    #2 reset = 1'b1;
    #1 check("async_rst_write", 64'(avm_write), 64'd0);
    do_reset();
    for (int i = 0; i < BL; i++) push(1'b0, 1'b0, 1'b1, 1'b0);
    plan_burst(1);
    wait_drain("drain_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
